// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: requester handshake, clear control and both register-file write ports
interface rf_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic clear;
  logic busy;
  logic clear_done;
  logic [ADDR_WIDTH-1:0] waddr_a;
  logic [ADDR_WIDTH-1:0] waddr_b;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic [DATA_WIDTH-1:0] wdata_b;
  logic we_a;
  logic we_b;
  modport master (
    output req_valid, req_addr, req_data, clear,
    input req_ready, busy, clear_done, waddr_a, wdata_a, we_a, waddr_b, wdata_b, we_b
  );
  modport slave (
    input req_valid, req_addr, req_data, clear,
    output req_ready, busy, clear_done, waddr_a, wdata_a, we_a, waddr_b, wdata_b, we_b
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin two-port register-file write arbiter with bulk clear
module rf_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  rf_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'((2 ** (ADDR_WIDTH - 1)) - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic [PW-1:0] p, p_n, idx;
  logic [ADDR_WIDTH-1:0] c, c_n, waddr_a_n, waddr_b_n;
  logic [DATA_WIDTH-1:0] wdata_a_n, wdata_b_n;
  logic [NUM_REQ-1:0] gnt;
  logic we_a_n, we_b_n, done_n, done_q;
  logic [ADDR_WIDTH-1:0] addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr[g] = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    state_n = state;
    p_n = p;
    c_n = c;
    idx = '0;
    gnt = '0;
    we_a_n = 1'b0;
    we_b_n = 1'b0;
    waddr_a_n = '0;
    waddr_b_n = '0;
    wdata_a_n = '0;
    wdata_b_n = '0;
    if (state == CLEAR) begin
      we_a_n = 1'b1;
      we_b_n = 1'b1;
      waddr_a_n = c << 1;
      waddr_b_n = (c << 1) | ADDR_WIDTH'(1);
      c_n = c + ADDR_WIDTH'(1);
      state_n = c == LAST ? IDLE : CLEAR;
    end else if (bus.clear) begin
      state_n = CLEAR;
      c_n = '0;
    end else begin
      // port B only takes a requester whose address differs from port A's
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = PW'((int'(p) + i) % NUM_REQ);
        if (bus.req_valid[idx] && !we_a_n) begin
          we_a_n = 1'b1;
          gnt[idx] = 1'b1;
          waddr_a_n = addr[idx];
          wdata_a_n = data[idx];
          p_n = PW'((int'(idx) + 1) % NUM_REQ);
        end else if (bus.req_valid[idx] && !we_b_n && addr[idx] != waddr_a_n) begin
          we_b_n = 1'b1;
          gnt[idx] = 1'b1;
          waddr_b_n = addr[idx];
          wdata_b_n = data[idx];
          p_n = PW'((int'(idx) + 1) % NUM_REQ);
        end
      end
    end
    done_n = state_n == CLEAR && c_n == LAST;
  end
  // ready is combinational but must read zero while reset is held
  assign bus.req_ready = rst_n ? gnt : '0;
  assign bus.busy = state == CLEAR;
  assign bus.clear_done = done_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p <= '0;
      c <= '0;
      done_q <= 1'b0;
      bus.we_a <= 1'b0;
      bus.we_b <= 1'b0;
      bus.waddr_a <= '0;
      bus.waddr_b <= '0;
      bus.wdata_a <= '0;
      bus.wdata_b <= '0;
    end else begin
      state <= state_n;
      p <= p_n;
      c <= c_n;
      done_q <= done_n;
      bus.we_a <= we_a_n;
      bus.we_b <= we_b_n;
      bus.waddr_a <= waddr_a_n;
      bus.waddr_b <= waddr_b_n;
      bus.wdata_a <= wdata_a_n;
      bus.wdata_b <= wdata_b_n;
    end
  end
endmodule
